// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter in front of the memory controller. Four sources
// (I-cache read, D-cache read, D-cache writeback, vector rd/wr) share one
// registered valid/ready request slot. Per-source busy flags allow one read
// in flight per source, and a timer per read source flags lost responses.
module mem_req_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DC_BLOCK_DW    = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ic_req_i,
  input  logic [ADDR_W-1:0]      ic_addr_i,
  output logic                   ic_ack_o,
  input  logic                   dc_rd_req_i,
  input  logic [ADDR_W-1:0]      dc_rd_addr_i,
  output logic                   dc_rd_ack_o,
  input  logic                   dc_wr_req_i,
  input  logic [ADDR_W-1:0]      dc_wr_addr_i,
  input  logic [DC_BLOCK_DW-1:0] dc_wr_data_i,
  output logic                   dc_wr_ack_o,
  input  logic                   vec_req_i,
  input  logic                   vec_we_i,
  input  logic [ADDR_W-1:0]      vec_addr_i,
  input  logic [31:0]            vec_data_i,
  output logic                   vec_ack_o,
  input  logic                   mem_ready_i,
  output logic                   mem_ic_rd_o,
  output logic                   mem_dc_rd_o,
  output logic                   mem_dc_wr_o,
  output logic                   mem_vec_rd_o,
  output logic                   mem_vec_wr_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  output logic [DC_BLOCK_DW-1:0] mem_data_o,
  input  logic                   mem_ic_rvalid_i,
  input  logic                   mem_dc_rvalid_i,
  input  logic                   mem_vec_rvalid_i,
  output logic                   ic_busy_o,
  output logic                   dc_busy_o,
  output logic                   vec_busy_o,
  output logic                   err_timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [1:0]             ptr_q, ptr_d;
  logic                   ic_rd_q, ic_rd_d, dc_rd_q, dc_rd_d, dc_wr_q, dc_wr_d;
  logic                   vec_rd_q, vec_rd_d, vec_wr_q, vec_wr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DC_BLOCK_DW-1:0] data_q, data_d;
  logic                   ic_busy_q, ic_busy_d, dc_busy_q, dc_busy_d;
  logic                   vec_busy_q, vec_busy_d;
  logic [CNT_W-1:0]       ic_cnt_q, ic_cnt_d, dc_cnt_q, dc_cnt_d;
  logic [CNT_W-1:0]       vec_cnt_q, vec_cnt_d;
  logic                   err_q, err_d;

  logic [3:0] elig;
  logic       held, can_load, grant_vld, load;
  logic [1:0] win, cand;

  function automatic logic [CNT_W-1:0] tick(input logic busy, input logic [CNT_W-1:0] cnt);
    if (!busy)               return '0;
    else if (cnt == CNT_MAX) return cnt;
    else                     return cnt + 1'b1;
  endfunction

  // Eligibility and rotating priority search starting at the pointer. A read
  // still waiting in the output slot blocks its own source so a second read
  // cannot be granted before the first one is marked busy.
  always_comb begin
    held     = ic_rd_q | dc_rd_q | dc_wr_q | vec_rd_q | vec_wr_q;
    can_load = ~held | mem_ready_i;
    elig[0]  = ic_req_i & ~ic_busy_q & ~ic_rd_q;
    elig[1]  = dc_rd_req_i & ~dc_busy_q & ~dc_rd_q;
    elig[2]  = dc_wr_req_i;
    elig[3]  = vec_req_i & (vec_we_i | (~vec_busy_q & ~vec_rd_q));
    grant_vld = 1'b0;
    win       = 2'd0;
    cand      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        win       = cand;
      end
    end
    load        = can_load & grant_vld;
    ic_ack_o    = load & (win == 2'd0);
    dc_rd_ack_o = load & (win == 2'd1);
    dc_wr_ack_o = load & (win == 2'd2);
    vec_ack_o   = load & (win == 2'd3);
  end

  // Next state of the output slot, pointer, busy flags and timeout timers.
  always_comb begin
    ic_rd_d  = ic_rd_q;
    dc_rd_d  = dc_rd_q;
    dc_wr_d  = dc_wr_q;
    vec_rd_d = vec_rd_q;
    vec_wr_d = vec_wr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ptr_d    = ptr_q;
    if (can_load) begin
      ic_rd_d  = 1'b0;
      dc_rd_d  = 1'b0;
      dc_wr_d  = 1'b0;
      vec_rd_d = 1'b0;
      vec_wr_d = 1'b0;
      if (grant_vld) begin
        ptr_d  = win + 2'd1;
        data_d = '0;
        case (win)
          2'd0: begin ic_rd_d = 1'b1; addr_d = ic_addr_i; end
          2'd1: begin dc_rd_d = 1'b1; addr_d = dc_rd_addr_i; end
          2'd2: begin dc_wr_d = 1'b1; addr_d = dc_wr_addr_i; data_d = dc_wr_data_i; end
          default: begin
            addr_d = vec_addr_i;
            if (vec_we_i) begin
              vec_wr_d     = 1'b1;
              data_d[31:0] = vec_data_i;
            end else begin
              vec_rd_d = 1'b1;
            end
          end
        endcase
      end
    end
    // set (handshake) takes priority over clear (rvalid)
    ic_busy_d  = (ic_rd_q & mem_ready_i) | (ic_busy_q & ~mem_ic_rvalid_i);
    dc_busy_d  = (dc_rd_q & mem_ready_i) | (dc_busy_q & ~mem_dc_rvalid_i);
    vec_busy_d = (vec_rd_q & mem_ready_i) | (vec_busy_q & ~mem_vec_rvalid_i);
    ic_cnt_d   = tick(ic_busy_q, ic_cnt_q);
    dc_cnt_d   = tick(dc_busy_q, dc_cnt_q);
    vec_cnt_d  = tick(vec_busy_q, vec_cnt_q);
    err_d      = err_q | (ic_cnt_d == CNT_MAX) | (dc_cnt_d == CNT_MAX) | (vec_cnt_d == CNT_MAX);
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= 2'd0;
      ic_rd_q    <= 1'b0;
      dc_rd_q    <= 1'b0;
      dc_wr_q    <= 1'b0;
      vec_rd_q   <= 1'b0;
      vec_wr_q   <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      ic_busy_q  <= 1'b0;
      dc_busy_q  <= 1'b0;
      vec_busy_q <= 1'b0;
      ic_cnt_q   <= '0;
      dc_cnt_q   <= '0;
      vec_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      ic_rd_q    <= ic_rd_d;
      dc_rd_q    <= dc_rd_d;
      dc_wr_q    <= dc_wr_d;
      vec_rd_q   <= vec_rd_d;
      vec_wr_q   <= vec_wr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ic_busy_q  <= ic_busy_d;
      dc_busy_q  <= dc_busy_d;
      vec_busy_q <= vec_busy_d;
      ic_cnt_q   <= ic_cnt_d;
      dc_cnt_q   <= dc_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      err_q      <= err_d;
    end
  end

  assign mem_ic_rd_o   = ic_rd_q;
  assign mem_dc_rd_o   = dc_rd_q;
  assign mem_dc_wr_o   = dc_wr_q;
  assign mem_vec_rd_o  = vec_rd_q;
  assign mem_vec_wr_o  = vec_wr_q;
  assign mem_addr_o    = addr_q;
  assign mem_data_o    = data_q;
  assign ic_busy_o     = ic_busy_q;
  assign dc_busy_o     = dc_busy_q;
  assign vec_busy_o    = vec_busy_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter (TIMEOUT_CYCLES overridden to 16).
module tb_mem_req_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_req_i, dc_rd_req_i, dc_wr_req_i, vec_req_i, vec_we_i;
  logic [AW-1:0] ic_addr_i, dc_rd_addr_i, dc_wr_addr_i, vec_addr_i;
  logic [DW-1:0] dc_wr_data_i;
  logic [31:0]   vec_data_i;
  logic          mem_ready_i, mem_ic_rvalid_i, mem_dc_rvalid_i, mem_vec_rvalid_i;
  logic          ic_ack_o, dc_rd_ack_o, dc_wr_ack_o, vec_ack_o;
  logic          mem_ic_rd_o, mem_dc_rd_o, mem_dc_wr_o, mem_vec_rd_o, mem_vec_wr_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          ic_busy_o, dc_busy_o, vec_busy_o, err_timeout_o;

  logic [4:0] strb;
  logic [3:0] acks;
  logic [2:0] busy;
  assign strb = {mem_ic_rd_o, mem_dc_rd_o, mem_dc_wr_o, mem_vec_rd_o, mem_vec_wr_o};
  assign acks = {ic_ack_o, dc_rd_ack_o, dc_wr_ack_o, vec_ack_o};
  assign busy = {ic_busy_o, dc_busy_o, vec_busy_o};

  int errors = 0;
  int checks = 0;

  mem_req_arbiter #(.ADDR_W(AW), .DC_BLOCK_DW(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_ack_o(ic_ack_o),
    .dc_rd_req_i(dc_rd_req_i), .dc_rd_addr_i(dc_rd_addr_i), .dc_rd_ack_o(dc_rd_ack_o),
    .dc_wr_req_i(dc_wr_req_i), .dc_wr_addr_i(dc_wr_addr_i), .dc_wr_data_i(dc_wr_data_i),
    .dc_wr_ack_o(dc_wr_ack_o),
    .vec_req_i(vec_req_i), .vec_we_i(vec_we_i), .vec_addr_i(vec_addr_i),
    .vec_data_i(vec_data_i), .vec_ack_o(vec_ack_o),
    .mem_ready_i(mem_ready_i),
    .mem_ic_rd_o(mem_ic_rd_o), .mem_dc_rd_o(mem_dc_rd_o), .mem_dc_wr_o(mem_dc_wr_o),
    .mem_vec_rd_o(mem_vec_rd_o), .mem_vec_wr_o(mem_vec_wr_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ic_rvalid_i(mem_ic_rvalid_i), .mem_dc_rvalid_i(mem_dc_rvalid_i),
    .mem_vec_rvalid_i(mem_vec_rvalid_i),
    .ic_busy_o(ic_busy_o), .dc_busy_o(dc_busy_o), .vec_busy_o(vec_busy_o),
    .err_timeout_o(err_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] a5_blk;

  initial begin
    a5_blk = {32{8'hA5}};
    rst_n = 1'b0;
    ic_req_i = 0; dc_rd_req_i = 0; dc_wr_req_i = 0; vec_req_i = 0; vec_we_i = 0;
    ic_addr_i = '0; dc_rd_addr_i = '0; dc_wr_addr_i = '0; vec_addr_i = '0;
    dc_wr_data_i = '0; vec_data_i = '0;
    mem_ready_i = 1; mem_ic_rvalid_i = 0; mem_dc_rvalid_i = 0; mem_vec_rvalid_i = 0;
    repeat (3) step();
    #1;
    chk("rst_strb", strb, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout_o, 0);
    chk("rst_acks", acks, 0);
    rst_n = 1'b1;

    // single IC read
    step(); ic_req_i = 1; ic_addr_i = 32'h100; #1;
    chk("ic_ack", acks, 4'b1000);
    step(); ic_req_i = 0; #1;
    chk("ic_strb", strb, 5'b10000);
    chk("ic_addr", mem_addr_o, 32'h100);
    chk("ic_busy_pre", busy, 3'b000);
    step(); #1;
    chk("ic_strb_gone", strb, 0);
    chk("ic_busy", busy, 3'b100);
    step(); mem_ic_rvalid_i = 1; #1;
    chk("ic_busy_hold", busy, 3'b100);
    step(); mem_ic_rvalid_i = 0; #1;
    chk("ic_busy_clr", busy, 3'b000);

    // reset to bring the pointer back to IC
    rst_n = 0; #1; rst_n = 1;

    // all four together
    step();
    ic_req_i = 1; ic_addr_i = 32'h100;
    dc_rd_req_i = 1; dc_rd_addr_i = 32'h200;
    dc_wr_req_i = 1; dc_wr_addr_i = 32'h300; dc_wr_data_i = {8{32'h1234_5678}};
    vec_req_i = 1; vec_we_i = 0; vec_addr_i = 32'h400;
    #1;
    chk("rr_ack0", acks, 4'b1000);
    step(); ic_req_i = 0; #1;
    chk("rr_strb0", strb, 5'b10000);
    chk("rr_addr0", mem_addr_o, 32'h100);
    chk("rr_ack1", acks, 4'b0100);
    step(); dc_rd_req_i = 0; #1;
    chk("rr_strb1", strb, 5'b01000);
    chk("rr_addr1", mem_addr_o, 32'h200);
    chk("rr_ack2", acks, 4'b0010);
    step(); dc_wr_req_i = 0; #1;
    chk("rr_strb2", strb, 5'b00100);
    chk("rr_addr2", mem_addr_o, 32'h300);
    chk("rr_data2", mem_data_o, {8{32'h1234_5678}});
    chk("rr_ack3", acks, 4'b0001);
    step(); vec_req_i = 0; #1;
    chk("rr_strb3", strb, 5'b00010);
    chk("rr_addr3", mem_addr_o, 32'h400);
    chk("rr_ack_none", acks, 0);
    step(); #1;
    chk("rr_strb_idle", strb, 0);
    chk("rr_busy", busy, 3'b111);
    mem_ic_rvalid_i = 1; mem_dc_rvalid_i = 1; mem_vec_rvalid_i = 1;
    step(); mem_ic_rvalid_i = 0; mem_dc_rvalid_i = 0; mem_vec_rvalid_i = 0; #1;
    chk("rr_busy_clr", busy, 0);

    // backpressure on a DC writeback
    step(); dc_wr_req_i = 1; dc_wr_addr_i = 32'h2000; dc_wr_data_i = a5_blk; mem_ready_i = 0; #1;
    chk("bp_ack", acks, 4'b0010);
    step(); dc_wr_req_i = 0; ic_req_i = 1; ic_addr_i = 32'h500; #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_strb", strb, 5'b00100);
      chk("bp_addr", mem_addr_o, 32'h2000);
      chk("bp_data", mem_data_o, a5_blk);
      chk("bp_noack", acks, 0);
      step(); #1;
    end
    mem_ready_i = 1; #1;
    chk("bp_strb_last", strb, 5'b00100);
    chk("bp_ic_ack", acks, 4'b1000);
    step(); ic_req_i = 0; #1;
    chk("bp_next_strb", strb, 5'b10000);
    chk("bp_next_addr", mem_addr_o, 32'h500);

    // second IC while busy, vector write meanwhile
    step();
    ic_req_i = 1; ic_addr_i = 32'h600;
    vec_req_i = 1; vec_we_i = 1; vec_addr_i = 32'h40; vec_data_i = 32'hDEAD_BEEF;
    #1;
    chk("b2_busy", busy, 3'b100);
    chk("b2_vec_ack", acks, 4'b0001);
    step(); vec_req_i = 0; vec_we_i = 0; #1;
    chk("vw_strb", strb, 5'b00001);
    chk("vw_addr", mem_addr_o, 32'h40);
    chk("vw_data", mem_data_o, 256'hDEAD_BEEF);
    chk("b2_noack", acks, 0);
    step(); #1;
    chk("vw_busy", busy, 3'b100);
    chk("b2_noack2", acks, 0);
    mem_ic_rvalid_i = 1; #1;
    chk("b2_noack_rv", acks, 0);
    step(); mem_ic_rvalid_i = 0; #1;
    chk("b2_busy_clr", busy, 0);
    chk("b2_ack", acks, 4'b1000);
    step(); ic_req_i = 0; #1;
    chk("b2_strb", strb, 5'b10000);
    chk("b2_addr", mem_addr_o, 32'h600);
    step(); mem_ic_rvalid_i = 1;
    step(); mem_ic_rvalid_i = 0; #1;
    chk("b2_idle", busy, 0);

    // timeout on a DC read that never returns
    dc_rd_req_i = 1; dc_rd_addr_i = 32'h700; #1;
    chk("to_ack", acks, 4'b0100);
    step(); dc_rd_req_i = 0; #1;
    chk("to_strb", strb, 5'b01000);
    step(); #1;
    chk("to_busy", busy, 3'b010);
    for (int i = 1; i < 16; i++) begin
      chk("to_err_early", err_timeout_o, 0);
      step(); #1;
    end
    chk("to_err_early", err_timeout_o, 0);
    step(); #1;
    chk("to_err_set", err_timeout_o, 1);
    repeat (4) step();
    #1;
    chk("to_err_sticky", err_timeout_o, 1);

    // asynchronous reset mid-operation, then a stray response
    rst_n = 0; #1;
    chk("mr_err", err_timeout_o, 0);
    chk("mr_busy", busy, 0);
    rst_n = 1;
    step(); mem_dc_rvalid_i = 1;
    step(); mem_dc_rvalid_i = 0; #1;
    chk("stray_busy", busy, 0);
    chk("stray_err", err_timeout_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits directly upstream of the main memory controller; the I-cache, D-cache and vector unit connect to this block, not to memory.
- Collects requests from four sources (I-cache read, D-cache read, D-cache writeback, vector read/write) and round-robin arbitrates among them.
- Issues exactly one request per handshake on a registered, valid/ready memory interface.
- Tracks outstanding reads so each read source has at most one in flight, and flags reads that never complete.

Parameters:
- ADDR_W, 32, address width.
- DC_BLOCK_DW, 256, D-cache writeback block width.
- TIMEOUT_CYCLES, 1024, cycles a read may stay outstanding before err_timeout_o is set.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ic_req_i  in  1  I-cache read request, held until ic_ack_o
- ic_addr_i  in  ADDR_W  I-cache read address
- ic_ack_o  out  1  one-cycle pulse: I-cache request accepted
- dc_rd_req_i  in  1  D-cache read request, held until dc_rd_ack_o
- dc_rd_addr_i  in  ADDR_W  D-cache read address
- dc_rd_ack_o  out  1  one-cycle pulse: D-cache read accepted
- dc_wr_req_i  in  1  D-cache writeback request, held until dc_wr_ack_o
- dc_wr_addr_i  in  ADDR_W  writeback address
- dc_wr_data_i  in  DC_BLOCK_DW  writeback data
- dc_wr_ack_o  out  1  one-cycle pulse: writeback accepted
- vec_req_i  in  1  vector request, held until vec_ack_o
- vec_we_i  in  1  vector request type: 1 = write, 0 = read
- vec_addr_i  in  ADDR_W  vector address
- vec_data_i  in  32  vector write data
- vec_ack_o  out  1  one-cycle pulse: vector request accepted
- mem_ready_i  in  1  memory can accept a request
- mem_ic_rd_o, mem_dc_rd_o, mem_dc_wr_o, mem_vec_rd_o, mem_vec_wr_o  out  1 each  one-hot request type to memory; at most one high
- mem_addr_o  out  ADDR_W  request address
- mem_data_o  out  DC_BLOCK_DW  write data; vector data zero-extended into [31:0]
- mem_ic_rvalid_i, mem_dc_rvalid_i, mem_vec_rvalid_i  in  1 each  read-response strobes from memory
- ic_busy_o, dc_busy_o, vec_busy_o  out  1 each  read outstanding for that source
- err_timeout_o  out  1  sticky: an outstanding read exceeded TIMEOUT_CYCLES

Behaviour:
- Reset: all memory request strobes 0, mem_addr_o/mem_data_o 0, all acks 0, busy flags 0, err_timeout_o 0, round-robin pointer at source 0 (I-cache).
- Source order for round-robin: 0 = IC, 1 = DC read, 2 = DC write, 3 = VEC.
- Eligibility:
  - IC eligible when ic_req_i & ~ic_busy.
  - DC read eligible when dc_rd_req_i & ~dc_busy.
  - DC write always eligible when requested.
  - VEC read eligible when ~vec_busy; VEC write always eligible.
- Output register: holds one request. It may load when empty, or in the same cycle the held request completes its handshake (mem strobe & mem_ready_i), giving back-to-back issue.
- Grant: on a load, pick the first eligible source starting at the pointer. Register type, address and data. Pulse that source's ack in the same cycle. Move the pointer to winner+1 mod 4.
- Latency: req_i to ack_o is 0 cycles when the output register can load. The strobe appears on the memory interface 1 cycle after the ack.
- Hold: while mem_ready_i=0, strobe, address and data stay stable. No new grant happens unless the register is freeing.
- Busy flags:
  - Set when a read is handed to memory (strobe & mem_ready_i).
  - Cleared by the matching rvalid.
  - If set and clear occur in the same cycle, set wins (cannot occur legally; defined for safety).
  - Writes never set busy.
- Stray rvalid with busy=0: ignored, no error.
- Timeout: one counter per read source. It counts while busy and resets when busy clears. Reaching TIMEOUT_CYCLES sets err_timeout_o. err_timeout_o clears only on reset. The counter saturates.
- Ordering: requests reach memory in grant order. A DC read following a DC write to the same address is therefore issued after the write.
- Mid-operation reset: all state is cleared immediately. Outstanding responses that arrive after reset are treated as stray.

Test Plan:
- Single IC read at 0x100, mem_ready_i=1:
  - ic_ack_o in the same cycle.
  - Next cycle mem_ic_rd_o=1 with mem_addr_o=0x100 for 1 cycle.
  - ic_busy_o=1 until mem_ic_rvalid_i.
- All four sources request together, pointer=0, ready always 1:
  - Acks arrive in order IC, DC-rd, DC-wr, VEC on consecutive cycles.
  - Memory strobes follow 1 cycle later, back-to-back.
- Backpressure:
  - Drop mem_ready_i for 5 cycles while a DC write (addr 0x2000, data 0xA5..A5) is held.
  - Strobe, address and data stay constant.
  - No further acks are issued.
  - Handshake completes on the first ready=1 cycle.
- Second IC request while ic_busy_o=1:
  - No ack until mem_ic_rvalid_i.
  - A VEC write requested meanwhile is still acked and issued.
- Vector write of 0xDEADBEEF to 0x40:
  - mem_vec_wr_o=1 and mem_data_o[31:0]=0xDEADBEEF with upper bits 0.
  - vec_busy_o stays 0.
- Timeout with TIMEOUT_CYCLES=16: issue a DC read and never return rvalid; err_timeout_o rises after 16 cycles of busy and stays high until rst_n.
